// File: rtl/spu_writeback_stager.sv
// rtl/spu_writeback_stager.sv - SPU writeback stager: per-pipe latency delay lines,
// register-file write ports and six-way forwarding from in-flight results.

module spu_wb_delay_line #(
   parameter int MAX_LAT = 7,
   parameter int LAT_W   = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [0:6]                 in_addr,
   input  logic [0:127]               in_data,
   input  logic [LAT_W-1:0]           in_lat,
   input  logic                       flush,
   output logic [MAX_LAT:1]           stage_valid,
   output logic [MAX_LAT:1][0:6]      stage_addr,
   output logic [MAX_LAT:1][0:127]    stage_data,
   output logic                       drop
);

   logic [MAX_LAT:1]        nxt_valid;
   logic [MAX_LAT:1][0:6]   nxt_addr;
   logic [MAX_LAT:1][0:127] nxt_data;
   logic                    lat_ok;

   always_comb begin
      nxt_valid = '0;
      nxt_addr  = stage_addr;
      nxt_data  = stage_data;
      drop      = 1'b0;
      lat_ok    = (in_lat != '0) && (in_lat <= LAT_W'(MAX_LAT));
      for (int k = 1; k < MAX_LAT; k++) begin
         nxt_valid[k] = stage_valid[k+1];
         nxt_addr[k]  = stage_addr[k+1];
         nxt_data[k]  = stage_data[k+1];
      end
      // A new result lands in the slot that retires exactly L edges from now;
      // if the entry shifting into that slot is live, the newcomer is the one dropped.
      if (in_valid && !flush) begin
         if (!lat_ok) begin
            drop = 1'b1;
         end else begin
            for (int k = 1; k <= MAX_LAT; k++) begin
               if (in_lat == LAT_W'(k)) begin
                  if (nxt_valid[k]) begin
                     drop = 1'b1;
                  end else begin
                     nxt_valid[k] = 1'b1;
                     nxt_addr[k]  = in_addr;
                     nxt_data[k]  = in_data;
                  end
               end
            end
         end
      end
      if (flush) nxt_valid = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_valid <= '0;
         stage_addr  <= '0;
         stage_data  <= '0;
      end else begin
         stage_valid <= nxt_valid;
         stage_addr  <= nxt_addr;
         stage_data  <= nxt_data;
      end
   end

endmodule

module spu_writeback_stager #(
   parameter int MAX_LAT = 7,
   parameter int LAT_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              even_valid,
   input  logic [0:6]        even_addr,
   input  logic [0:127]      even_data,
   input  logic [LAT_W-1:0]  even_lat,
   input  logic              odd_valid,
   input  logic [0:6]        odd_addr,
   input  logic [0:127]      odd_data,
   input  logic [LAT_W-1:0]  odd_lat,
   input  logic              flush,
   input  logic [0:6]        fwd_addr_1,
   input  logic [0:6]        fwd_addr_2,
   input  logic [0:6]        fwd_addr_3,
   input  logic [0:6]        fwd_addr_4,
   input  logic [0:6]        fwd_addr_5,
   input  logic [0:6]        fwd_addr_6,
   output logic              fwd_hit_1,
   output logic              fwd_hit_2,
   output logic              fwd_hit_3,
   output logic              fwd_hit_4,
   output logic              fwd_hit_5,
   output logic              fwd_hit_6,
   output logic [0:127]      fwd_data_1,
   output logic [0:127]      fwd_data_2,
   output logic [0:127]      fwd_data_3,
   output logic [0:127]      fwd_data_4,
   output logic [0:127]      fwd_data_5,
   output logic [0:127]      fwd_data_6,
   output logic              reg_write_en_1,
   output logic [0:6]        reg_write_addr_1,
   output logic [0:127]      reg_write_data_1,
   output logic              reg_write_en_2,
   output logic [0:6]        reg_write_addr_2,
   output logic [0:127]      reg_write_data_2,
   output logic              collision_err,
   output logic              wr_conflict
);

   logic [MAX_LAT:1]        ev_v, od_v;
   logic [MAX_LAT:1][0:6]   ev_a, od_a;
   logic [MAX_LAT:1][0:127] ev_d, od_d;
   logic                    ev_drop, od_drop;
   logic                    same_addr;
   logic [0:6]              fwd_addr_arr [6];
   logic                    fwd_hit_arr  [6];
   logic [0:127]            fwd_data_arr [6];

   spu_wb_delay_line #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) u_even (
      .clk(clk), .rst(rst),
      .in_valid(even_valid), .in_addr(even_addr), .in_data(even_data), .in_lat(even_lat),
      .flush(flush),
      .stage_valid(ev_v), .stage_addr(ev_a), .stage_data(ev_d), .drop(ev_drop)
   );

   spu_wb_delay_line #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) u_odd (
      .clk(clk), .rst(rst),
      .in_valid(odd_valid), .in_addr(odd_addr), .in_data(odd_data), .in_lat(odd_lat),
      .flush(flush),
      .stage_valid(od_v), .stage_addr(od_a), .stage_data(od_d), .drop(od_drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     collision_err <= 1'b0;
      else if (ev_drop || od_drop) collision_err <= 1'b1;
   end

   // Odd wins a same-register retirement so the later-issued value lands last.
   assign same_addr        = ev_v[1] && od_v[1] && (ev_a[1] == od_a[1]);
   assign wr_conflict      = !rst && same_addr;
   assign reg_write_en_1   = !rst && ev_v[1] && !same_addr;
   assign reg_write_addr_1 = reg_write_en_1 ? ev_a[1] : '0;
   assign reg_write_data_1 = reg_write_en_1 ? ev_d[1] : '0;
   assign reg_write_en_2   = !rst && od_v[1];
   assign reg_write_addr_2 = reg_write_en_2 ? od_a[1] : '0;
   assign reg_write_data_2 = reg_write_en_2 ? od_d[1] : '0;

   assign fwd_addr_arr = '{fwd_addr_1, fwd_addr_2, fwd_addr_3, fwd_addr_4, fwd_addr_5, fwd_addr_6};

   // Ascending scan with even before odd: the last match is the highest stage, odd on a tie.
   always_comb begin
      for (int j = 0; j < 6; j++) begin
         fwd_hit_arr[j]  = 1'b0;
         fwd_data_arr[j] = '0;
         for (int k = 1; k <= MAX_LAT; k++) begin
            if (ev_v[k] && (ev_a[k] == fwd_addr_arr[j])) begin
               fwd_hit_arr[j]  = 1'b1;
               fwd_data_arr[j] = ev_d[k];
            end
            if (od_v[k] && (od_a[k] == fwd_addr_arr[j])) begin
               fwd_hit_arr[j]  = 1'b1;
               fwd_data_arr[j] = od_d[k];
            end
         end
         if (rst) begin
            fwd_hit_arr[j]  = 1'b0;
            fwd_data_arr[j] = '0;
         end
      end
   end

   assign fwd_hit_1  = fwd_hit_arr[0];
   assign fwd_hit_2  = fwd_hit_arr[1];
   assign fwd_hit_3  = fwd_hit_arr[2];
   assign fwd_hit_4  = fwd_hit_arr[3];
   assign fwd_hit_5  = fwd_hit_arr[4];
   assign fwd_hit_6  = fwd_hit_arr[5];
   assign fwd_data_1 = fwd_data_arr[0];
   assign fwd_data_2 = fwd_data_arr[1];
   assign fwd_data_3 = fwd_data_arr[2];
   assign fwd_data_4 = fwd_data_arr[3];
   assign fwd_data_5 = fwd_data_arr[4];
   assign fwd_data_6 = fwd_data_arr[5];

endmodule

// File: tb/tb_spu_writeback_stager.sv
// tb/tb_spu_writeback_stager.sv - directed-vector bench for spu_writeback_stager.

module tb_spu_writeback_stager;

   logic           clk = 1'b0;
   logic           rst;
   logic           even_valid, odd_valid, flush;
   logic [0:6]     even_addr, odd_addr;
   logic [0:127]   even_data, odd_data;
   logic [2:0]     even_lat, odd_lat;
   logic [0:6]     fwd_addr [1:6];
   logic           fwd_hit  [1:6];
   logic [0:127]   fwd_data [1:6];
   logic           reg_write_en_1, reg_write_en_2;
   logic [0:6]     reg_write_addr_1, reg_write_addr_2;
   logic [0:127]   reg_write_data_1, reg_write_data_2;
   logic           collision_err, wr_conflict;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [0:127] DATA_AA = {16{8'hAA}};
   localparam logic [0:127] DATA_A  = {16{8'h5A}};
   localparam logic [0:127] DATA_B  = {16{8'hB7}};
   localparam logic [0:127] DATA_C  = {16{8'hC3}};
   localparam logic [0:127] DATA_D  = {16{8'hD4}};

   always #5 clk = ~clk;

   spu_writeback_stager dut (
      .clk(clk), .rst(rst),
      .even_valid(even_valid), .even_addr(even_addr), .even_data(even_data), .even_lat(even_lat),
      .odd_valid(odd_valid), .odd_addr(odd_addr), .odd_data(odd_data), .odd_lat(odd_lat),
      .flush(flush),
      .fwd_addr_1(fwd_addr[1]), .fwd_addr_2(fwd_addr[2]), .fwd_addr_3(fwd_addr[3]),
      .fwd_addr_4(fwd_addr[4]), .fwd_addr_5(fwd_addr[5]), .fwd_addr_6(fwd_addr[6]),
      .fwd_hit_1(fwd_hit[1]), .fwd_hit_2(fwd_hit[2]), .fwd_hit_3(fwd_hit[3]),
      .fwd_hit_4(fwd_hit[4]), .fwd_hit_5(fwd_hit[5]), .fwd_hit_6(fwd_hit[6]),
      .fwd_data_1(fwd_data[1]), .fwd_data_2(fwd_data[2]), .fwd_data_3(fwd_data[3]),
      .fwd_data_4(fwd_data[4]), .fwd_data_5(fwd_data[5]), .fwd_data_6(fwd_data[6]),
      .reg_write_en_1(reg_write_en_1), .reg_write_addr_1(reg_write_addr_1),
      .reg_write_data_1(reg_write_data_1),
      .reg_write_en_2(reg_write_en_2), .reg_write_addr_2(reg_write_addr_2),
      .reg_write_data_2(reg_write_data_2),
      .collision_err(collision_err), .wr_conflict(wr_conflict)
   );

   task automatic clear_inputs();
      even_valid = 0; even_addr = '0; even_data = '0; even_lat = '0;
      odd_valid  = 0; odd_addr  = '0; odd_data  = '0; odd_lat  = '0;
      flush = 0;
      for (int i = 1; i <= 6; i++) fwd_addr[i] = 7'd127;
   endtask

   task automatic do_reset();
      rst = 1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      for (int i = 1; i <= 6; i++) fwd_addr[i] = 7'd0;
      @(negedge clk);
      vectors++;
      if ({reg_write_en_1, reg_write_en_2, wr_conflict, collision_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b required 0000",
                  {reg_write_en_1, reg_write_en_2, wr_conflict, collision_err});
      end
      vectors++;
      if (fwd_hit[1] !== 1'b0 || fwd_data[1] !== '0 || reg_write_addr_1 !== '0) begin
         miscompares++;
         $display("FAIL reset_fwd: hit=%b data=%h addr1=%0d required 0", fwd_hit[1], fwd_data[1], reg_write_addr_1);
      end
      rst = 0;
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_latency3();
      do_reset();
      even_valid = 1; even_addr = 7'd5; even_data = DATA_AA; even_lat = 3'd3;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         clear_inputs();
         vectors++;
         if (n == 3) begin
            if (reg_write_en_1 !== 1'b1 || reg_write_addr_1 !== 7'd5 || reg_write_data_1 !== DATA_AA) begin
               miscompares++;
               $display("FAIL lat3_write: en=%b addr=%0d data=%h required 1/5/%h",
                        reg_write_en_1, reg_write_addr_1, reg_write_data_1, DATA_AA);
            end
         end else if (reg_write_en_1 !== 1'b0 || reg_write_addr_1 !== '0 || reg_write_data_1 !== '0) begin
            miscompares++;
            $display("FAIL lat3_idle_c%0d: en=%b addr=%0d data=%h required all 0",
                     n, reg_write_en_1, reg_write_addr_1, reg_write_data_1);
         end
      end
   endtask

   task automatic test_same_addr();
      do_reset();
      even_valid = 1; even_addr = 7'd9; even_data = DATA_C; even_lat = 3'd1;
      odd_valid  = 1; odd_addr  = 7'd9; odd_data  = DATA_D; odd_lat  = 3'd1;
      @(negedge clk);
      clear_inputs();
      vectors++;
      if (reg_write_en_2 !== 1'b1 || reg_write_addr_2 !== 7'd9 || reg_write_data_2 !== DATA_D) begin
         miscompares++;
         $display("FAIL conflict_port2: en=%b addr=%0d data=%h required 1/9/%h",
                  reg_write_en_2, reg_write_addr_2, reg_write_data_2, DATA_D);
      end
      vectors++;
      if (reg_write_en_1 !== 1'b0 || wr_conflict !== 1'b1 || reg_write_data_1 !== '0) begin
         miscompares++;
         $display("FAIL conflict_port1: en1=%b wr_conflict=%b data1=%h required 0/1/0",
                  reg_write_en_1, wr_conflict, reg_write_data_1);
      end
      @(negedge clk);
      vectors++;
      if (wr_conflict !== 1'b0 || reg_write_en_2 !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_pulse: wr_conflict=%b en2=%b required 0/0", wr_conflict, reg_write_en_2);
      end
   endtask

   task automatic test_collision();
      do_reset();
      even_valid = 1; even_addr = 7'd3; even_data = DATA_A; even_lat = 3'd4;
      @(negedge clk);
      even_addr = 7'd7; even_data = DATA_B; even_lat = 3'd3;
      @(negedge clk);
      clear_inputs();
      vectors++;
      if (collision_err !== 1'b1) begin
         miscompares++;
         $display("FAIL collision_set: got %b required 1", collision_err);
      end
      for (int n = 2; n <= 5; n++) begin
         vectors++;
         if (n == 4) begin
            if (reg_write_en_1 !== 1'b1 || reg_write_addr_1 !== 7'd3 || reg_write_data_1 !== DATA_A) begin
               miscompares++;
               $display("FAIL collision_keep: en=%b addr=%0d required 1/3", reg_write_en_1, reg_write_addr_1);
            end
         end else if (reg_write_en_1 !== 1'b0 || collision_err !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_c%0d: en=%b err=%b required 0/1", n, reg_write_en_1, collision_err);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_forwarding();
      logic [6:1] exp_hit;
      do_reset();
      even_valid = 1; even_addr = 7'd12; even_data = DATA_A; even_lat = 3'd5;
      odd_valid  = 1; odd_addr  = 7'd12; odd_data  = DATA_B; odd_lat  = 3'd2;
      @(negedge clk);
      clear_inputs();
      for (int i = 1; i <= 6; i++) fwd_addr[i] = 7'd12;
      fwd_addr[2] = 7'd13;
      exp_hit = 6'b111101;
      #1;
      for (int i = 1; i <= 6; i++) begin
         vectors++;
         if (fwd_hit[i] !== exp_hit[i] || fwd_data[i] !== (exp_hit[i] ? DATA_A : 128'd0)) begin
            miscompares++;
            $display("FAIL fwd_lookup%0d: hit=%b data=%h required %b", i, fwd_hit[i], fwd_data[i], exp_hit[i]);
         end
      end
      for (int n = 2; n <= 6; n++) begin
         @(negedge clk);
         vectors++;
         if (n == 2 && (reg_write_en_2 !== 1'b1 || reg_write_data_2 !== DATA_B)) begin
            miscompares++;
            $display("FAIL fwd_odd_retire: en2=%b data=%h required 1/%h", reg_write_en_2, reg_write_data_2, DATA_B);
         end
         if (n <= 5 && (fwd_hit[1] !== 1'b1 || fwd_data[1] !== DATA_A)) begin
            miscompares++;
            $display("FAIL fwd_hold_c%0d: hit=%b data=%h required 1/%h", n, fwd_hit[1], fwd_data[1], DATA_A);
         end
         if (n == 6 && (fwd_hit[1] !== 1'b0 || fwd_data[1] !== '0)) begin
            miscompares++;
            $display("FAIL fwd_after_retire: hit=%b data=%h required 0/0", fwd_hit[1], fwd_data[1]);
         end
      end
      clear_inputs();
      even_valid = 1; even_addr = 7'd20; even_data = DATA_C; even_lat = 3'd2;
      odd_valid  = 1; odd_addr  = 7'd20; odd_data  = DATA_D; odd_lat  = 3'd2;
      @(negedge clk);
      clear_inputs();
      fwd_addr[4] = 7'd20;
      #1;
      vectors++;
      if (fwd_hit[4] !== 1'b1 || fwd_data[4] !== DATA_D) begin
         miscompares++;
         $display("FAIL fwd_tie_odd: hit=%b data=%h required 1/%h", fwd_hit[4], fwd_data[4], DATA_D);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_flush();
      do_reset();
      even_valid = 1; even_addr = 7'd40; even_data = DATA_C; even_lat = 3'd6;
      @(negedge clk);
      even_addr = 7'd41; even_data = DATA_D; even_lat = 3'd1;
      @(negedge clk);
      clear_inputs();
      flush = 1;
      fwd_addr[1] = 7'd40;
      #1;
      vectors++;
      if (reg_write_en_1 !== 1'b1 || reg_write_addr_1 !== 7'd41 || reg_write_data_1 !== DATA_D) begin
         miscompares++;
         $display("FAIL flush_cycle_write: en=%b addr=%0d required 1/41", reg_write_en_1, reg_write_addr_1);
      end
      vectors++;
      if (fwd_hit[1] !== 1'b1 || fwd_data[1] !== DATA_C) begin
         miscompares++;
         $display("FAIL flush_fwd_before: hit=%b required 1", fwd_hit[1]);
      end
      @(negedge clk);
      flush = 0;
      for (int n = 0; n < 7; n++) begin
         vectors++;
         if (reg_write_en_1 !== 1'b0 || reg_write_en_2 !== 1'b0 || fwd_hit[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_quiet_c%0d: en1=%b en2=%b hit=%b required 0/0/0",
                     n, reg_write_en_1, reg_write_en_2, fwd_hit[1]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_bad_lat_and_async_reset();
      do_reset();
      even_valid = 1; even_addr = 7'd50; even_data = DATA_A; even_lat = 3'd0;
      @(negedge clk);
      even_addr = 7'd51; even_data = DATA_B; even_lat = 3'd5;
      vectors++;
      if (collision_err !== 1'b1 || reg_write_en_1 !== 1'b0) begin
         miscompares++;
         $display("FAIL lat0_drop: err=%b en1=%b required 1/0", collision_err, reg_write_en_1);
      end
      @(negedge clk);
      clear_inputs();
      fwd_addr[1] = 7'd51;
      fwd_addr[2] = 7'd50;
      #1;
      vectors++;
      if (fwd_hit[1] !== 1'b1 || fwd_hit[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL lat0_fwd: hit51=%b hit50=%b required 1/0", fwd_hit[1], fwd_hit[2]);
      end
      @(negedge clk);
      #2 rst = 1;
      #1;
      vectors++;
      if ({reg_write_en_1, reg_write_en_2, wr_conflict, collision_err, fwd_hit[1]} !== 5'b00000
          || fwd_data[1] !== '0) begin
         miscompares++;
         $display("FAIL async_reset: en1=%b en2=%b conf=%b err=%b hit=%b required all 0",
                  reg_write_en_1, reg_write_en_2, wr_conflict, collision_err, fwd_hit[1]);
      end
      @(negedge clk);
      rst = 0;
      for (int n = 0; n < 7; n++) begin
         @(negedge clk);
         vectors++;
         if (reg_write_en_1 !== 1'b0 || fwd_hit[1] !== 1'b0 || collision_err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_c%0d: en1=%b hit=%b err=%b required 0/0/0",
                     n, reg_write_en_1, fwd_hit[1], collision_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency3();
      test_same_addr();
      test_collision();
      test_forwarding();
      test_flush();
      test_bad_lat_and_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spu_writeback_stager.md
Name: spu_writeback_stager

Overview:
Writeback stager for the SPU. It accepts completed even-pipe and odd-pipe results, each tagged with a fixed unit latency. It holds each result in a per-pipe delay line so that the result reaches the register-file write ports exactly at its architectural writeback cycle. It drives the register file's two write ports (even → port 1, odd → port 2) and supplies six forwarding lookups from in-flight results.

Parameters:
MAX_LAT, 7, deepest delay-line stage; legal latencies are 1..MAX_LAT.
LAT_W, 3, width of latency tag; must hold MAX_LAT.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
even_valid  input  1  even-pipe result present this cycle
even_addr  input  7 [0:6]  destination register
even_data  input  128 [0:127]  result value
even_lat  input  LAT_W  cycles until writeback (1..MAX_LAT)
odd_valid / odd_addr / odd_data / odd_lat  input  1/7/128/LAT_W  same as even, odd pipe
flush  input  1  discard all in-flight results
fwd_addr_1..fwd_addr_6  input  7 each  forwarding lookup addresses
fwd_hit_1..fwd_hit_6  output  1 each  an in-flight result matches
fwd_data_1..fwd_data_6  output  128 each  matching in-flight value, 0 when no hit
reg_write_en_1 / reg_write_addr_1 / reg_write_data_1  output  1/7/128  even write port
reg_write_en_2 / reg_write_addr_2 / reg_write_data_2  output  1/7/128  odd write port
collision_err  output  1  sticky: a result was dropped
wr_conflict  output  1  pulse: same-address dual write suppressed on port 1

Behaviour:
- State: per pipe, stages s[1..MAX_LAT], each {valid, addr[0:6], data[0:127]}.
- Reset: all stage valids 0, collision_err 0. All outputs read 0 while rst is high: write enables, fwd_hit, fwd_data, wr_conflict.
- Shift: every edge, s[k] <= s[k+1] for k < MAX_LAT; s[MAX_LAT].valid <= 0.
- Insert: on an edge with pipe valid and legal lat L, the entry is written into s[L], overriding the shifted-in value.
- Write timing: write port outputs are combinational from s[1].
  - reg_write_en is high in the cycle beginning L-1 edges after the sampling edge.
  - The register file captures the write on the L-th edge after the sampling edge.
  - L=1: write visible immediately after the sampling edge.
- Collision: drop the new entry and set collision_err (held until rst) if either holds:
  - lat = 0 or lat > MAX_LAT;
  - the shifted-in s[L+1] entry is valid, i.e. the target slot is occupied.
  - The existing entry is always preserved.
- Even/odd are independent delay lines; both may insert in the same cycle.
- Same-address dual write: if s[1] of both pipes is valid with equal addr:
  - reg_write_en_1 is forced 0 (odd result wins);
  - wr_conflict = 1 for that cycle.
- Inactive write ports drive addr and data 0.
- Forwarding (combinational), per lookup k:
  - Hit = any valid stage, either pipe, whose addr equals fwd_addr_k.
  - Selection: the highest stage index, i.e. the latest to retire. Tie at the same index goes to odd.
  - Stages include s[1], the entry being written this cycle.
- Flush:
  - On an edge with flush=1, all stage valids clear and same-cycle inserts are dropped.
  - The write presented from s[1] during the flush cycle still completes.
  - Flush does not clear collision_err.
- Reset mid-operation: in-flight entries are lost; no write is emitted after rst deasserts until new inserts.
- No backpressure: valid inputs are never stalled.

Test Plan:
- Even insert addr=5, data=0xAA..AA, lat=3 at edge E0 → reg_write_en_1=1, addr=5, data=0xAA..AA only in the cycle after E2; zero elsewhere.
- Odd lat=1 addr=9 and even lat=1 addr=9 same edge → reg_write_en_2=1 addr=9 odd data; reg_write_en_1=0; wr_conflict=1 for one cycle.
- Even lat=4 addr=3 at E0, then even lat=3 addr=7 at E1 → second dropped; collision_err=1 and sticky; only addr=3 written (after E3).
- Even lat=5 addr=12 data=A at E0, odd lat=2 addr=12 data=B at E0; fwd_addr_1=12 after E0 → fwd_hit_1=1, fwd_data_1=A; after odd retires, still A until even retires; then hit=0.
- Insert lat=6 at E0, flush at E2 → no write ever emitted; an entry with lat=1 inserted at E1 still writes during the flush cycle.
- even_lat=0 → dropped, collision_err=1. Then assert rst asynchronously mid-flight → all outputs 0 immediately; collision_err cleared.
